pipe_reg: RTL and testbench
===========================

# pipe_reg

Parametrised elastic pipeline register that replaces the fixed enable/flush stage registers between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one packed bundle of WIDTH bits with a valid/ready handshake, an optional skid entry for full throughput under a registered ready, and a flush that inserts a bubble. On a bubble, only the control bits selected by CTRL_MASK are zeroed. Two saturating performance counters, one for stalls and one for flush drops, feed the debug/out port.

## Interface
- WIDTH, 64: bundle width in bits; legal range is 1..256.
- CTRL_MASK, all ones: WIDTH-bit mask of control bits (regwrite, mem write, halt, out_en, …). These bits read 0 whenever out_valid=0.
- SKID, 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all held entries this cycle.
- in_valid  in  1  upstream has a bundle.
- in_ready  out  1  stage can accept this cycle.
- in_dat  in  WIDTH  upstream bundle.
- out_valid  out  1  out_dat holds a live bundle.
- out_ready  in  1  downstream consumes this cycle.
- out_dat  out  WIDTH  head bundle.
- stall_cnt  out  16  cycles with out_valid=1 and out_ready=0; saturates at 0xFFFF.
- drop_cnt  out  16  entries discarded by flush; saturates at 0xFFFF.

## Operation
- A transfer occurs when valid=1 and ready=1 on the same port in the same cycle.
- SKID=1 state machine, with states EMPTY, ONE and FULL.
  - in_ready = (state != FULL), decoded from registered state.
  - out_valid = (state != EMPTY).
  - EMPTY: in_valid → ONE, and head ← in_dat.
  - ONE:
    - in_valid and out_ready → ONE, and head ← in_dat.
    - in_valid and !out_ready → FULL, and skid ← in_dat.
    - !in_valid and out_ready → EMPTY.
    - otherwise, hold.
  - FULL: out_ready → ONE, and head ← skid. No input is accepted in FULL.
- SKID=0: one entry.
  - in_ready = !out_valid | out_ready (combinational).
  - A transfer loads head.
  - out_valid clears when out_ready=1 and there is no input transfer.
- Flush:
  - Highest priority below reset.
  - Next state is EMPTY, and any same-cycle input transfer is discarded.
  - drop_cnt += number of live entries (0, 1 or 2) plus 1 if in_valid & in_ready; saturating.
  - Data bits outside CTRL_MASK in head hold their value; skid contents are don't-care.
- out_dat = head & (out_valid ? all ones : ~CTRL_MASK). Control fields of a bubble therefore always read 0.
- Reset:
  - state → EMPTY.
  - head and skid → 0.
  - stall_cnt and drop_cnt → 0.
  - Counters do not count during reset.
- Reset values of outputs:
  - out_valid=0, out_dat=0, stall_cnt=0, drop_cnt=0.
  - in_ready=1 for SKID=1. For SKID=0, in_ready=1 because out_valid=0.
- Ordering is strictly FIFO: the skid entry is never presented before the head entry.

## Timing
- Latency is one cycle: a bundle accepted at edge N appears on out_dat with out_valid=1 after edge N, and is consumable in cycle N+1.
- Throughput is one bundle per cycle in both modes when out_ready is held at 1.
- SKID=1: in_ready depends only on registered state, so there is no ready→ready combinational path. One extra beat is absorbed when downstream stalls.
- SKID=0: there is a combinational path from out_ready to in_ready.
- Flush in cycle N: out_valid=0 after edge N. An input presented in cycle N+1 is accepted normally.
- stall_cnt increments at the edge ending each stalled cycle. A simultaneous flush in that cycle still counts the stall.

## Structure
- Shared package cpu_pipe_pkg:
  - typedef enum logic [1:0] pipe_state_t {PS_EMPTY, PS_ONE, PS_FULL}.
  - localparam PERF_CNT_W = 16.
- Sub-module sat_counter (parameter W; ports clk, reset, en, inc[1:0], q): used twice, for stall_cnt and drop_cnt.
- Head and skid are plain registers with enables. The existing flopr cell is reused for them.
- The stage-specific bundles (ID/EX, etc.) are packed structs in cpu_pipe_pkg, and each is cast to WIDTH at the instantiation.

## Test plan
- Reset with WIDTH=16, CTRL_MASK=16'hF000 → out_valid=0, out_dat=0, in_ready=1, both counters 0.
- SKID=1, out_ready=1, in_dat=0x1234, 0x5678, 0x9ABC in consecutive cycles → the same values on out_dat one cycle later each, with no bubbles.
- SKID=1: stream 0xA001, 0xA002, 0xA003 with out_ready=0 for 3 cycles.
  - in_ready drops after the second accept.
  - stall_cnt=3.
  - After release, outputs appear in order 0xA001, 0xA002, then 0xA003.
- Flush in FULL with in_valid=1 → out_valid=0 next cycle, out_dat=0x0002 (control bits 0xA000 masked off), drop_cnt=2.
- SKID=0: out_ready toggling 1,0,1 with continuous input.
  - in_ready follows out_ready whenever out_valid=1.
  - No data is lost or duplicated.
- Force stall_cnt to 0xFFFE, then stall 3 cycles → value 0xFFFF and holds. Reset mid-stream in FULL → EMPTY, counters 0 next cycle.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared types for the CPU pipeline stage registers: handshake state encoding,
// performance counter width and the per-stage bundle layouts.
package cpu_pipe_pkg;

  localparam int PERF_CNT_W = 16;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  // Stage bundles; each is cast to the WIDTH of the pipe_reg that carries it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic        halt;
    logic        out_en;
    logic [4:0]  rd;
    logic [31:0] alu_res;
    logic [31:0] wdata;
  } ex_mem_t;

endpackage

// File: rtl/flopr.sv
// Resettable register with load enable; used for the head and skid entries.
module flopr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order in which always blocks execute.
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter that adds 0..3 per enabled cycle and sticks at all ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [1:0]   inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {{(W-1){1'b0}}, inc};
    cnt_d = sum[W] ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset)   cnt_q <= '0;
    else if (en) cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_reg.sv
// Elastic valid/ready pipeline register between CPU stages, with optional skid
// entry, flush-to-bubble and saturating stall/drop performance counters.
module pipe_reg
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] CTRL_MASK = '1,
  parameter bit               SKID      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_dat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_dat,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] drop_cnt
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] skid_q;
  logic             head_en;
  logic             skid_en;
  logic             in_xfer;
  logic [1:0]       live_n;
  logic [1:0]       drop_inc;
  logic             stall_en;

  assign out_valid = (state_q != PS_EMPTY);
  assign in_xfer   = in_valid & in_ready;

  if (SKID) begin : g_skid_ready
    // Registered-state decode only: no out_ready -> in_ready path.
    assign in_ready = (state_q != PS_FULL);
  end else begin : g_pass_ready
    assign in_ready = ~out_valid | out_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= PS_EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // block leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d = state_q;
    head_en = 1'b0;
    head_d  = in_dat;
    skid_en = 1'b0;
    if (SKID) begin
      unique case (state_q)
        PS_EMPTY: begin
          if (in_valid) begin
            state_d = PS_ONE;
            head_en = 1'b1;
          end
        end
        PS_ONE: begin
          if (in_valid && out_ready) begin
            head_en = 1'b1;
          end else if (in_valid) begin
            state_d = PS_FULL;
            skid_en = 1'b1;
          end else if (out_ready) begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (out_ready) begin
            state_d = PS_ONE;
            head_en = 1'b1;
            head_d  = skid_q;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end else begin
      if (in_xfer) begin
        state_d = PS_ONE;
        head_en = 1'b1;
      end else if (out_ready) begin
        state_d = PS_EMPTY;
      end
    end
    // Flush leaves head untouched so its non-control bits survive the bubble.
    if (flush) begin
      state_d = PS_EMPTY;
      head_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  flopr #(.W(WIDTH)) u_head (
    .clk   (clk),
    .reset (reset),
    .en    (head_en),
    .d     (head_d),
    .q     (head_q)
  );

  flopr #(.W(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_dat),
    .q     (skid_q)
  );

  assign out_dat = head_q & (out_valid ? {WIDTH{1'b1}} : ~CTRL_MASK);

  always_comb begin
    unique case (state_q)
      PS_ONE:  live_n = 2'd1;
      PS_FULL: live_n = 2'd2;
      default: live_n = 2'd0;
    endcase
    drop_inc = live_n + {1'b0, in_xfer};
  end

  assign stall_en = out_valid & ~out_ready;

  sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_en),
    .inc   (2'd1),
    .q     (stall_cnt)
  );

  sat_counter #(.W(PERF_CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush),
    .inc   (drop_inc),
    .q     (drop_cnt)
  );

endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg: one SKID=1 and one SKID=0 instance (WIDTH=16,
// CTRL_MASK=16'hF000) driven from shared inputs and checked against vectors.
module tb_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_dat;
  logic        out_ready;

  logic        rdy1, vld1, rdy0, vld0;
  logic [15:0] dat1, dat0, stall1, stall0, drop1, drop0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_reg #(.WIDTH(16), .CTRL_MASK(16'hF000), .SKID(1'b1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (rdy1),
    .in_dat    (in_dat),
    .out_valid (vld1),
    .out_ready (out_ready),
    .out_dat   (dat1),
    .stall_cnt (stall1),
    .drop_cnt  (drop1)
  );

  pipe_reg #(.WIDTH(16), .CTRL_MASK(16'hF000), .SKID(1'b0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (rdy0),
    .in_dat    (in_dat),
    .out_valid (vld0),
    .out_ready (out_ready),
    .out_dat   (dat0),
    .stall_cnt (stall0),
    .drop_cnt  (drop0)
  );

  typedef struct {
    bit          skid;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_dat;
    logic        out_ready;
    logic        rdy_pre;
    logic        valid;
    logic [15:0] dat;
    logic        rdy;
    logic [15:0] stall;
    logic [15:0] drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit skid, logic fl, logic iv, logic [15:0] d,
                              logic ordy, logic rpre, logic v, logic [15:0] ed,
                              logic r, logic [15:0] st, logic [15:0] dr);
    vec_t t;
    t.skid = skid; t.flush = fl; t.in_valid = iv; t.in_dat = d;
    t.out_ready = ordy; t.rdy_pre = rpre; t.valid = v; t.dat = ed;
    t.rdy = r; t.stall = st; t.drop = dr;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic run_step(input vec_t v, input string name);
    flush     = v.flush;
    in_valid  = v.in_valid;
    in_dat    = v.in_dat;
    out_ready = v.out_ready;
    #2;
    check({name, ".rdy_pre"}, v.skid ? rdy1 : rdy0, v.rdy_pre);
    @(posedge clk);
    #1;
    check({name, ".valid"}, v.skid ? vld1 : vld0, v.valid);
    check({name, ".dat"},   v.skid ? dat1 : dat0, v.dat);
    check({name, ".rdy"},   v.skid ? rdy1 : rdy0, v.rdy);
    check({name, ".stall"}, v.skid ? stall1 : stall0, v.stall);
    check({name, ".drop"},  v.skid ? drop1 : drop0, v.drop);
  endtask

  task automatic reset_all(input string name);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_dat = 16'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({name, ".vld1"},   vld1,   1'b0);
    check({name, ".dat1"},   dat1,   16'h0);
    check({name, ".rdy1"},   rdy1,   1'b1);
    check({name, ".stall1"}, stall1, 16'h0);
    check({name, ".drop1"},  drop1,  16'h0);
    check({name, ".vld0"},   vld0,   1'b0);
    check({name, ".dat0"},   dat0,   16'h0);
    check({name, ".rdy0"},   rdy0,   1'b1);
    reset = 1'b0;
  endtask

  initial begin
    // SKID=1: streaming, skid absorb, drain, bubbles, flushes, refill to FULL.
    tbl.push_back(mk(1, 0, 1, 16'h1234, 1, 1, 1, 16'h1234, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 16'h5678, 1, 1, 1, 16'h5678, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 16'h9ABC, 1, 1, 1, 16'h9ABC, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 16'h0ABC, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 16'hA001, 0, 1, 1, 16'hA001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 16'hA002, 0, 1, 1, 16'hA001, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 16'hA003, 0, 0, 1, 16'hA001, 0, 2, 0));
    tbl.push_back(mk(1, 0, 1, 16'hA003, 0, 0, 1, 16'hA001, 0, 3, 0));
    tbl.push_back(mk(1, 0, 1, 16'hA003, 1, 0, 1, 16'hA002, 1, 3, 0));
    tbl.push_back(mk(1, 0, 1, 16'hA003, 1, 1, 1, 16'hA003, 1, 3, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 16'h0003, 1, 3, 0));
    tbl.push_back(mk(1, 0, 1, 16'hA002, 0, 1, 1, 16'hA002, 1, 3, 0));
    tbl.push_back(mk(1, 0, 1, 16'hA00F, 0, 1, 1, 16'hA002, 0, 4, 0));
    tbl.push_back(mk(1, 1, 1, 16'hA0EE, 0, 0, 0, 16'h0002, 1, 5, 2));
    tbl.push_back(mk(1, 0, 1, 16'hA0B0, 1, 1, 1, 16'hA0B0, 1, 5, 2));
    tbl.push_back(mk(1, 1, 1, 16'hA0C0, 0, 1, 0, 16'h00B0, 1, 6, 4));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 0, 16'h00B0, 1, 6, 4));
    tbl.push_back(mk(1, 0, 1, 16'hC001, 0, 1, 1, 16'hC001, 1, 6, 4));
    tbl.push_back(mk(1, 0, 1, 16'hC002, 0, 1, 1, 16'hC001, 0, 7, 4));
    // SKID=0: out_ready 1,0,1 with continuous input, then a flush of an input.
    tbl.push_back(mk(0, 0, 1, 16'hB001, 1, 1, 1, 16'hB001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'hB002, 0, 0, 1, 16'hB001, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 16'hB002, 1, 1, 1, 16'hB002, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 16'hB003, 1, 1, 1, 16'hB003, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0003, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 16'hB004, 0, 1, 0, 16'h0003, 1, 1, 1));

    reset_all("reset0");
    for (int i = 0; i < 19; i++) run_step(tbl[i], $sformatf("skid1[%0d]", i));

    // Reset taken while FULL: empty and counters cleared after one edge.
    reset = 1'b1; in_valid = 1'b1; in_dat = 16'hC003; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_full.valid", vld1,   1'b0);
    check("rst_full.dat",   dat1,   16'h0);
    check("rst_full.rdy",   rdy1,   1'b1);
    check("rst_full.stall", stall1, 16'h0);
    check("rst_full.drop",  drop1,  16'h0);
    reset = 1'b0;

    reset_all("reset1");
    for (int i = 19; i < tbl.size(); i++) run_step(tbl[i], $sformatf("skid0[%0d]", i - 19));

    // Stall counter saturation on the SKID=1 instance.
    reset_all("reset2");
    run_step(mk(1, 0, 1, 16'hD001, 0, 1, 1, 16'hD001, 1, 0, 0), "sat_load");
    in_valid = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check("sat.fffe", stall1, 16'hFFFE);
    @(posedge clk);
    #1;
    check("sat.ffff", stall1, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    check("sat.hold", stall1, 16'hFFFF);
    check("sat.head", dat1,   16'hD001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
